prim_rom_reader: RTL and testbench

- Read initiator for the single-port ROM primitive (1-cycle registered read latency; rdata held while req low).
- Fetches a programmed span of consecutive ROM words and streams them out on a valid/ready interface with full backpressure.
- Sits between ROM macro and consumers such as integrity checkers, boot loaders and DMA.

---
 rtl/prim_rom_reader_pkg.sv | 15 +
 rtl/prim_rom_reader_fifo.sv | 56 +++++
 rtl/prim_rom_reader.sv | 145 ++++++++++++++
 tb/tb_prim_rom_reader.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/prim_rom_reader_pkg.sv
// Shared types and constants for the ROM span reader and its skid FIFO.
package prim_rom_reader_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } rom_rd_state_e;

   localparam int FifoDepth = 2;
   localparam int FifoPtrW  = 1;
   localparam int FifoOccW  = 2;

endpackage

// File: rtl/prim_rom_reader_fifo.sv
// Two-entry synchronous FIFO holding {data, last} words returned by the ROM.
module prim_rom_reader_fifo
   import prim_rom_reader_pkg::*;
#(
   parameter int Width = 32
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                push_i,
   input  logic [Width-1:0]    wdata_i,
   input  logic                wlast_i,
   input  logic                pop_i,
   output logic [Width-1:0]    rdata_o,
   output logic                rlast_o,
   output logic                full_o,
   output logic                empty_o,
   output logic [FifoOccW-1:0] occ_o
);

   typedef struct packed {
      logic [Width-1:0] data;
      logic             last;
   } rom_rd_entry_t;

   rom_rd_entry_t        mem_q [FifoDepth];
   logic [FifoPtrW-1:0]  wr_ptr_q, rd_ptr_q;
   logic [FifoOccW-1:0]  occ_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
      end else begin
         if (push_i) wr_ptr_q <= wr_ptr_q + FifoPtrW'(1);
         if (pop_i)  rd_ptr_q <= rd_ptr_q + FifoPtrW'(1);
         case ({push_i, pop_i})
            2'b10:   occ_q <= occ_q + FifoOccW'(1);
            2'b01:   occ_q <= occ_q - FifoOccW'(1);
            default: occ_q <= occ_q;
         endcase
      end
   end

   // Storage carries no reset; the read side is qualified by empty_o.
   always_ff @(posedge clk_i) begin
      if (push_i) mem_q[wr_ptr_q] <= '{data: wdata_i, last: wlast_i};
   end

   assign rdata_o = mem_q[rd_ptr_q].data;
   assign rlast_o = mem_q[rd_ptr_q].last;
   assign occ_o   = occ_q;
   assign empty_o = (occ_q == '0);
   assign full_o  = (occ_q == FifoOccW'(FifoDepth));

endmodule

// File: rtl/prim_rom_reader.sv
// Streams a span of consecutive ROM words onto a valid/ready interface.
// Optional running checksum output enabled by PRIM_ROM_READER_CHECKSUM_EN.
module prim_rom_reader
   import prim_rom_reader_pkg::*;
#(
   parameter  int Width = 32,
   parameter  int Depth = 2048,
   localparam int Aw    = $clog2(Depth),
   localparam int CntW  = Aw + 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [Aw-1:0]    base_addr_i,
   input  logic [CntW-1:0]  count_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             rom_req_o,
   output logic [Aw-1:0]    rom_addr_o,
   input  logic [Width-1:0] rom_rdata_i,
   output logic             data_valid_o,
   input  logic             data_ready_i,
   output logic [Width-1:0] data_o,
`ifdef PRIM_ROM_READER_CHECKSUM_EN
   output logic [Width-1:0] checksum_o,
`endif
   output logic             data_last_o
);

   rom_rd_state_e        state_q, state_d;
   logic [Aw-1:0]        addr_q, addr_d;
   logic [CntW-1:0]      remain_q, remain_d;
   logic                 inflight_q, inflight_last_q;

   logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [FifoOccW-1:0]  fifo_occ;
   logic [Width-1:0]     head_data;
   logic                 head_last;
   logic [FifoOccW:0]    outstanding;
   logic                 handshake, start_ok;

   function automatic logic [Aw-1:0] next_addr(input logic [Aw-1:0] a);
      return (a == Aw'(Depth - 1)) ? '0 : a + Aw'(1);
   endfunction

   // A request is allowed only while buffered plus in-flight words leave room.
   assign outstanding = (FifoOccW+1)'(fifo_occ) + (FifoOccW+1)'(inflight_q);
   assign rom_req_o   = (state_q == FETCH) && !fifo_full
                        && (outstanding < (FifoOccW+1)'(FifoDepth));
   assign rom_addr_o  = addr_q;
   assign start_ok    = (state_q == IDLE) && start_i;

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      remain_d = remain_q;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               if (count_i != '0) begin
                  addr_d   = base_addr_i;
                  remain_d = count_i;
                  state_d  = FETCH;
               end else begin
                  state_d  = DONE;
               end
            end
         end
         FETCH: begin
            if (rom_req_o) begin
               addr_d   = next_addr(addr_q);
               remain_d = remain_q - CntW'(1);
               if (remain_q == CntW'(1)) state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (handshake && data_last_o) state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q         <= IDLE;
         addr_q          <= '0;
         remain_q        <= '0;
         inflight_q      <= 1'b0;
         inflight_last_q <= 1'b0;
      end else begin
         state_q         <= state_d;
         addr_q          <= addr_d;
         remain_q        <= remain_d;
         inflight_q      <= rom_req_o;
         inflight_last_q <= rom_req_o && (remain_q == CntW'(1));
      end
   end

   // The word arriving from the ROM bypasses an empty FIFO; it is buffered
   // only when it cannot be handed over in its arrival cycle.
   assign fifo_push = inflight_q && !(fifo_empty && data_ready_i);
   assign fifo_pop  = !fifo_empty && data_ready_i;

   prim_rom_reader_fifo #(
      .Width (Width)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (fifo_push),
      .wdata_i (rom_rdata_i),
      .wlast_i (inflight_last_q),
      .pop_i   (fifo_pop),
      .rdata_o (head_data),
      .rlast_o (head_last),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .occ_o   (fifo_occ)
   );

   assign data_valid_o = !fifo_empty || inflight_q;
   assign data_o       = !fifo_empty ? head_data
                       : (inflight_q ? rom_rdata_i : '0);
   assign data_last_o  = !fifo_empty ? head_last : (inflight_q && inflight_last_q);
   assign handshake    = data_valid_o && data_ready_i;

   assign busy_o = (state_q != IDLE);
   assign done_o = (state_q == DONE);

`ifdef PRIM_ROM_READER_CHECKSUM_EN
   logic [Width-1:0] checksum_q;

   always_ff @(posedge clk_i) begin
      if (rst_i)          checksum_q <= '0;
      else if (start_ok)  checksum_q <= '0;
      else if (handshake) checksum_q <= checksum_q + data_o;
   end

   assign checksum_o = checksum_q;
`else
   logic unused_start_ok;
   assign unused_start_ok = start_ok;
`endif

endmodule

// File: tb/tb_prim_rom_reader.sv
// Randomized bench for prim_rom_reader against a span/queue reference model.
// Define PRIM_ROM_READER_CHECKSUM_EN to also check checksum_o.
module tb_prim_rom_reader;

   localparam int W = 32;
   localparam int D = 2048;

   logic          clk, rst_i, start_i;
   logic [10:0]   base_addr_i;
   logic [11:0]   count_i;
   logic          busy_o, done_o, rom_req_o;
   logic [10:0]   rom_addr_o;
   logic [W-1:0]  rom_rdata;
   logic          data_valid_o, data_ready_i, data_last_o;
   logic [W-1:0]  data_o;
`ifdef PRIM_ROM_READER_CHECKSUM_EN
   logic [W-1:0]  checksum_o;
`endif

   logic [W-1:0]  mem [0:D-1];
   int            checks = 0;
   int            errors = 0;

   prim_rom_reader #(.Width(W), .Depth(D)) dut (
      .clk_i        (clk),
      .rst_i        (rst_i),
      .start_i      (start_i),
      .base_addr_i  (base_addr_i),
      .count_i      (count_i),
      .busy_o       (busy_o),
      .done_o       (done_o),
      .rom_req_o    (rom_req_o),
      .rom_addr_o   (rom_addr_o),
      .rom_rdata_i  (rom_rdata),
      .data_valid_o (data_valid_o),
      .data_ready_i (data_ready_i),
      .data_o       (data_o),
`ifdef PRIM_ROM_READER_CHECKSUM_EN
      .checksum_o   (checksum_o),
`endif
      .data_last_o  (data_last_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ROM primitive: one-cycle registered read, data held while req is low.
   always @(posedge clk) begin
      if (rom_req_o) rom_rdata <= mem[rom_addr_o];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_busy"},  32'(busy_o),       0);
      chk({tag, "_done"},  32'(done_o),       0);
      chk({tag, "_req"},   32'(rom_req_o),    0);
      chk({tag, "_addr"},  32'(rom_addr_o),   0);
      chk({tag, "_valid"}, 32'(data_valid_o), 0);
      chk({tag, "_data"},  data_o,            0);
      chk({tag, "_last"},  32'(data_last_o),  0);
   endtask

   // mode: 0 ready high, 1 ready pattern 1-0-0-1, 2 random ready.
   task automatic run_span(input int base, input int cnt, input int mode,
                           input int rst_after, input bit noise);
      logic [W-1:0] exp_q [$];
      logic [W-1:0] sum, prev_d;
      int           nreq, nhs, first_v, last_hs, limit;
      bit           done_seen, prev_v, prev_r, prev_l;
      exp_q.delete();
      for (int i = 0; i < cnt; i++) exp_q.push_back(mem[(base + i) % D]);
      nreq = 0; nhs = 0; first_v = -1; last_hs = -1; sum = '0;
      done_seen = 0; prev_v = 0; prev_r = 0; prev_l = 0; prev_d = '0;
      limit = 4 * cnt + 20;
      for (int cyc = 0; cyc < limit && !done_seen; cyc++) begin
         @(negedge clk);
         if (rst_after >= 0 && nhs == rst_after) begin
            rst_i = 1'b1; start_i = 1'b0;
            @(negedge clk);
            rst_i = 1'b0;
            #1;
            check_all_zero("midrst");
            repeat (4) begin
               @(negedge clk); #1;
               chk("midrst_nodone",  32'(done_o),       0);
               chk("midrst_novalid", 32'(data_valid_o), 0);
            end
            return;
         end
         if (cyc == 0) begin
            start_i = 1'b1; base_addr_i = 11'(base); count_i = 12'(cnt);
         end else if (noise && busy_o && $urandom_range(0, 2) == 0) begin
            start_i = 1'b1; base_addr_i = 11'($urandom); count_i = 12'($urandom_range(1, 40));
         end else begin
            start_i = 1'b0;
         end
         case (mode)
            0:       data_ready_i = 1'b1;
            1:       data_ready_i = (cyc % 4 == 0) || (cyc % 4 == 3);
            default: data_ready_i = 1'($urandom_range(0, 1));
         endcase
         #1;
         if (cyc > 0) chk("busy", 32'(busy_o), 1);
         if (rom_req_o) begin
            chk("req_room",  32'((nreq - nhs) < 2), 1);
            chk("req_addr",  32'(rom_addr_o), 32'((base + nreq) % D));
            chk("req_count", 32'(nreq < cnt), 1);
            nreq++;
         end
         if (data_valid_o) begin
            if (first_v < 0) begin
               first_v = cyc;
               chk("first_valid_cyc", cyc, 2);
            end
            if (prev_v && !prev_r) begin
               chk("hold_data", data_o, prev_d);
               chk("hold_last", 32'(data_last_o), 32'(prev_l));
            end
            if (data_ready_i) begin
               if (nhs < cnt) begin
                  chk("data", data_o, exp_q[nhs]);
                  chk("last", 32'(data_last_o), 32'(nhs == cnt - 1));
               end else begin
                  chk("extra_beat", nhs + 1, cnt);
               end
               sum = sum + data_o;
               nhs++;
               last_hs = cyc;
            end
         end else if (prev_v && !prev_r) begin
            chk("hold_valid", 32'(data_valid_o), 1);
         end
         prev_v = data_valid_o; prev_r = data_ready_i;
         prev_d = data_o;       prev_l = data_last_o;
         if (done_o) begin
            done_seen = 1;
            chk("done_beats", nhs, cnt);
            chk("done_cyc", cyc, (cnt == 0) ? 1 : last_hs + 1);
`ifdef PRIM_ROM_READER_CHECKSUM_EN
            chk("checksum", checksum_o, sum);
`endif
         end
      end
      start_i = 1'b0;
      chk("done_seen", 32'(done_seen), 1);
      @(negedge clk); #1;
      chk("idle_busy", 32'(busy_o), 0);
      chk("idle_done", 32'(done_o), 0);
`ifdef PRIM_ROM_READER_CHECKSUM_EN
      chk("checksum_hold", checksum_o, sum);
`endif
   endtask

   initial begin
      rst_i = 1'b1; start_i = 1'b0; base_addr_i = '0; count_i = '0;
      data_ready_i = 1'b0; rom_rdata = '0;
      for (int a = 0; a < D; a++) mem[a] = 32'(a * 3);
      repeat (3) @(negedge clk);
      #1;
      check_all_zero("reset");
`ifdef PRIM_ROM_READER_CHECKSUM_EN
      chk("reset_checksum", checksum_o, 0);
`endif
      @(negedge clk);
      rst_i = 1'b0;

      run_span(32'h010, 4, 0, -1, 0);
      for (int a = 0; a < D; a++) mem[a] = $urandom;
      run_span(32'h100, 6, 1, -1, 0);
      run_span(32'h7FE, 4, 0, -1, 0);
      run_span(32'h7FD, 5, 1, -1, 1);
      run_span(32'h055, 0, 0, -1, 0);
      run_span(32'h123, 2048, 2, -1, 1);
      run_span(32'h020, 8, 0, 3, 0);
      run_span(32'h020, 8, 0, -1, 0);
      mem[32'h40] = 32'h0000_0001;
      mem[32'h41] = 32'h0000_0002;
      mem[32'h42] = 32'hFFFF_FFFF;
      run_span(32'h040, 3, 0, -1, 1);
      for (int t = 0; t < 8; t++)
         run_span(int'($urandom_range(0, D - 1)), int'($urandom_range(1, 24)), 2, -1, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
